// File: rtl/boolean_law_checker.sv
// Sweeps every (x, y) operand pair through a selected boolean identity and
// compares LHS against RHS, counting mismatches and recording the first one.
module boolean_law_checker #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         mode,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               bad_mode,
    output logic [2*WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0]   first_x,
    output logic [WIDTH-1:0]   first_y,
    output logic [WIDTH-1:0]   cur_x,
    output logic [WIDTH-1:0]   cur_y,
    output logic [WIDTH-1:0]   lhs,
    output logic [WIDTH-1:0]   rhs
);

    localparam int CW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [CW:0]      err_q, err_d;
    logic [WIDTH-1:0] fx_q, fx_d;
    logic [WIDTH-1:0] fy_q, fy_d;
    logic             pass_q, pass_d;
    logic             bad_q, bad_d;
    logic             mismatch;
    logic             mode_legal;

    // Counter is {y, x} so x varies fastest.
    assign cur_x      = cnt_q[WIDTH-1:0];
    assign cur_y      = cnt_q[CW-1:WIDTH];
    assign mode_legal = (mode <= 3'd4);

    always_comb begin
        lhs = '0;
        rhs = '0;
        if (state_q == S_SWEEP) begin
            case (mode_q)
                3'd0: begin
                    lhs = cur_x & (cur_x | cur_y);
                    rhs = cur_x;
                end
                3'd1: begin
                    lhs = cur_x | (cur_x & cur_y);
                    rhs = cur_x;
                end
                3'd2: begin
                    lhs = ~(cur_x & cur_y);
                    rhs = ~cur_x | ~cur_y;
                end
                3'd3: begin
                    lhs = ~(cur_x | cur_y);
                    rhs = ~cur_x & ~cur_y;
                end
                // Deliberately false identity: proves the checker can fail.
                3'd4: begin
                    lhs = cur_x & cur_y;
                    rhs = cur_x;
                end
                default: begin
                    lhs = '0;
                    rhs = '0;
                end
            endcase
        end
    end

    assign mismatch = (lhs != rhs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        pass_d  = pass_q;
        bad_d   = bad_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d  = '0;
                    fx_d   = '0;
                    fy_d   = '0;
                    pass_d = 1'b0;
                    cnt_d  = '0;
                    if (mode_legal) begin
                        mode_d  = mode;
                        bad_d   = 1'b0;
                        state_d = S_SWEEP;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        fx_d = cur_x;
                        fy_d = cur_y;
                    end
                end
                // The last pair is evaluated in the same cycle we decide to stop.
                if (&cnt_q) begin
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            err_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            pass_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            pass_q  <= pass_d;
            bad_q   <= bad_d;
        end
    end

    assign busy     = (state_q == S_SWEEP);
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign bad_mode = bad_q;
    assign err_cnt  = err_q;
    assign first_x  = fx_q;
    assign first_y  = fy_q;

endmodule

// File: tb/tb_boolean_law_checker.sv
// Directed bench for boolean_law_checker at WIDTH=2 with hand-computed results.
module tb_boolean_law_checker;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   mode;
    logic         busy, done, pass, bad_mode;
    logic [2*W:0] err_cnt;
    logic [W-1:0] first_x, first_y, cur_x, cur_y, lhs, rhs;

    int n_chk  = 0;
    int n_fail = 0;

    boolean_law_checker #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .bad_mode(bad_mode),
        .err_cnt(err_cnt), .first_x(first_x), .first_y(first_y),
        .cur_x(cur_x), .cur_y(cur_y), .lhs(lhs), .rhs(rhs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] m_lhs(input logic [2:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
        case (m)
            3'd0:    return x & (x | y);
            3'd1:    return x | (x & y);
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x & y;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] m_rhs(input logic [2:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
        case (m)
            3'd0, 3'd1, 3'd4: return x;
            3'd2:             return ~x | ~y;
            3'd3:             return ~x & ~y;
            default:          return '0;
        endcase
    endfunction

    // inj >= 0 pulses start (with mode 4) on that sweep cycle; it must be ignored.
    task automatic do_run(input logic [2:0] m, input int inj, input int exp_busy,
                          input int exp_err, input int efx, input int efy,
                          input logic exp_pass, input logic exp_bad);
        int         nb;
        bit         got;
        logic [W-1:0] ex, ey;
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        nb  = 0;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (busy) begin
                ex = nb[W-1:0];
                ey = nb[2*W-1:W];
                check("cur_x", cur_x, ex);
                check("cur_y", cur_y, ey);
                check("lhs", lhs, m_lhs(m, ex, ey));
                check("rhs", rhs, m_rhs(m, ex, ey));
                check("done_in_sweep", done, 0);
                if (nb == 0) check("err_cleared", err_cnt, 0);
                if (nb == inj) begin
                    start = 1'b1;
                    mode  = 3'd4;
                end else begin
                    start = 1'b0;
                end
                nb++;
            end else if (done) begin
                got = 1;
                check("pass_at_done", pass, exp_pass);
                check("lhs_at_done", lhs, 0);
            end
            tick();
        end
        start = 1'b0;
        check("busy_cycles", nb, exp_busy);
        check("done_seen", got, 1);
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
        check("err_cnt", err_cnt, exp_err);
        check("first_x", first_x, efx);
        check("first_y", first_y, efy);
        check("pass_held", pass, exp_pass);
        check("bad_mode", bad_mode, exp_bad);
        tick();
        check("err_cnt_held", err_cnt, exp_err);
    endtask

    initial begin
        int ndone;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_bad", bad_mode, 0);
        check("rst_err", err_cnt, 0);
        check("rst_cur", {cur_y, cur_x}, 0);
        check("rst_first", {first_y, first_x}, 0);
        check("rst_lhs_rhs", {lhs, rhs}, 0);

        do_run(3'd0, -1, 16, 0, 0, 0, 1'b1, 1'b0);
        do_run(3'd1, -1, 16, 0, 0, 0, 1'b1, 1'b0);
        do_run(3'd2, -1, 16, 0, 0, 0, 1'b1, 1'b0);
        do_run(3'd3, -1, 16, 0, 0, 0, 1'b1, 1'b0);
        do_run(3'd4, -1, 16, 7, 1, 0, 1'b0, 1'b0);
        do_run(3'd6, -1, 0, 0, 0, 0, 1'b0, 1'b1);
        do_run(3'd0, 3, 16, 0, 0, 0, 1'b1, 1'b0);
        do_run(3'd4, -1, 16, 7, 1, 0, 1'b0, 1'b0);
        do_run(3'd4, -1, 16, 7, 1, 0, 1'b0, 1'b0);

        // Reset on the fifth sweep cycle, after pairs 0..3 (three mismatches).
        start = 1'b1;
        mode  = 3'd4;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_err", err_cnt, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_first", {first_y, first_x}, 0);
        check("mid_rst_cur", {cur_y, cur_x}, 0);
        check("mid_rst_lhs_rhs", {lhs, rhs}, 0);
        check("mid_rst_pass_bad", {pass, bad_mode}, 0);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) ndone++;
            tick();
        end
        check("no_activity_after_rst", ndone, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/boolean_law_checker.md
Name: boolean_law_checker

Overview:
- Parametrised, self-sequencing successor to the single-bit boolean identity demonstrators used in the lab-2 set.
- Sweeps every pair of WIDTH-bit operands (x, y) through a selected identity and compares LHS against RHS bitwise.
- Counts mismatching pairs, records the first failing pair, and reports pass/fail with a done pulse.
- Used as a synthesizable self-check for the law modules and as a lab FSM exercise.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..8. The sweep covers 2^(2*WIDTH) pairs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep. Sampled only in IDLE.
- mode  input  3  identity select. Latched when start is accepted.
- busy  output  1  high while in SWEEP.
- done  output  1  one-cycle pulse marking the end of a sweep.
- pass  output  1  1 when the last sweep had zero mismatches and a legal mode.
- bad_mode  output  1  the last accepted mode was illegal.
- err_cnt  output  2*WIDTH+1  number of mismatching (x, y) pairs in the last sweep.
- first_x  output  WIDTH  x operand of the first mismatch (0 if none).
- first_y  output  WIDTH  y operand of the first mismatch (0 if none).
- cur_x  output  WIDTH  operand currently under test.
- cur_y  output  WIDTH  operand currently under test.
- lhs  output  WIDTH  LHS for the current pair. Combinational; 0 outside SWEEP.
- rhs  output  WIDTH  RHS for the current pair. Combinational; 0 outside SWEEP.

Behaviour:
- Identities, all bitwise over WIDTH:
  - mode 0: x&(x|y) vs x (AND absorption).
  - mode 1: x|(x&y) vs x (OR absorption).
  - mode 2: ~(x&y) vs ~x|~y.
  - mode 3: ~(x|y) vs ~x&~y.
  - mode 4: x&y vs x. This is deliberately false and exists as a checker self-test.
  - modes 5-7: illegal.
- Reset values: state=IDLE; pair counter=0; every output=0.
- rst has priority over all other inputs in every state. A reset mid-sweep discards all results.
- Pair counter is 2*WIDTH bits, {y, x}, with x in the low half so x varies fastest. cur_x and cur_y are the two halves.
- IDLE:
  - If start=1 and mode is legal: latch mode, clear err_cnt/first_x/first_y/pass/bad_mode, counter=0, go to SWEEP.
  - If start=1 and mode is illegal: set bad_mode=1, pass=0, err_cnt=0, go to DONE with no sweep.
  - If start=0: no change; results from the last sweep are held.
- SWEEP:
  - Each cycle evaluates one pair. mismatch = (lhs != rhs).
  - On mismatch, err_cnt increments. If err_cnt was 0 before this increment, first_x/first_y capture cur_x/cur_y.
  - When the counter reaches all-ones, that pair is evaluated, then the FSM goes to DONE. The counter wraps to 0 and is not reused.
  - start is ignored; the latched mode is used throughout.
- DONE:
  - Lasts one cycle: done=1, pass=(err_cnt==0 && !bad_mode). Then go to IDLE.
  - pass, err_cnt, first_x, first_y and bad_mode hold until the next accepted start or rst.
- Latency: start sampled at edge k gives busy=1 on cycles k+1..k+N, where N=2^(2*WIDTH), and done=1 on cycle k+N+1. Illegal mode gives done at cycle k+1.
- err_cnt cannot overflow: its maximum value is N, and the width is 2*WIDTH+1.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=2, mode=0, start pulse:
  - busy high for exactly 16 cycles, then done for 1 cycle.
  - err_cnt=0, pass=1, first_x=first_y=0.
- WIDTH=2, modes 1, 2 and 3 in turn: each gives err_cnt=0 and pass=1. lhs equals rhs on every SWEEP cycle.
- WIDTH=2, mode=4:
  - err_cnt=7 (16 minus the 9 pairs where x is a subset of y).
  - first_x=1, first_y=0, pass=0.
- mode=6 with start: done on the next cycle, bad_mode=1, pass=0, busy never asserted.
- Back-to-back runs:
  - Pulse start=1 with mode=4 during a mode-0 sweep: ignored; mode-0 results are intact.
  - A following mode-4 run clears the old results at its start and reports err_cnt=7.
- Reset mid-sweep: assert rst for 1 cycle at cycle 5 of a sweep. All outputs go to 0, the FSM returns to IDLE, and no done pulse occurs.
